ternary_layer_sequencer: RTL and testbench
==========================================

Name: ternary_layer_sequencer

Overview:
Time-multiplexes one ternary dot-product datapath across N_NEURONS stored weight sets, forming one perceptron layer.
- Accepts a 4-bit binary input vector over a valid/ready handshake.
- Evaluates one neuron per cycle and returns all neuron sums as a packed vector over a second valid/ready handshake.
- Sits between the input-vector source (pins or a previous layer) and the output consumer.
- A config port loads the per-neuron weight bytes.

Parameters:
N_NEURONS, 4, number of neurons in the layer (2..16); sets the weight bank depth and the output vector width.
SUM_W, 4, width of each neuron result, signed two's complement; must be at least 4.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  weight write strobe
cfg_addr  in  $clog2(N_NEURONS)  neuron index to write
cfg_wdata  in  8  ternary weight byte: four 2-bit crumbs, crumb k = bits [2k+1:2k]
cfg_err  out  1  one-cycle pulse when a write is rejected
in_valid  in  1  input vector valid
in_ready  out  1  sequencer can accept an input vector
in_vec  in  4  binary inputs; bit k pairs with crumb k
out_valid  out  1  result vector valid
out_ready  in  1  consumer accepts the result
out_vec  out  N_NEURONS*SUM_W  neuron n result in bits [n*SUM_W +: SUM_W]
busy  out  1  high in RUN or DONE

Behaviour:
- Reset is synchronous and active-high on clk. On reset:
  - state=IDLE; all weight bytes=8'h00; out_vec=0; out_valid=0; cfg_err=0; neuron index=0.
- Crumb decode, per input bit k:
  - 01 -> +in_vec[k]
  - 11 -> -in_vec[k]
  - 00 and 10 -> 0
- Neuron sum: four terms added, range -4..+4, held as SUM_W-bit signed two's complement. There is no overflow for SUM_W>=4.
- FSM states and transitions:
  - IDLE: in_ready=1. On an in_valid handshake edge: latch in_vec, index=0, go to RUN.
  - RUN: in_ready=0. Each cycle computes neuron[index] from the latched vector and writes its out_vec slot, then index++. After the slot for N_NEURONS-1 is written, go to DONE.
  - DONE: out_valid=1, out_vec stable. On an out_ready edge: out_valid=0, go to IDLE.
- Latency: out_valid rises exactly N_NEURONS clock edges after the input handshake edge.
- Back-to-back operation: in_ready is asserted only in IDLE, so the earliest next accept is the cycle after the DONE handshake. There is no overlap.
- out_vec slots not yet rewritten during RUN keep their previous values. Consumers sample only when out_valid=1.
- Config writes:
  - Performed only when state==IDLE.
  - cfg_we outside IDLE is ignored, and cfg_err pulses high for the following cycle.
  - cfg_addr >= N_NEURONS is ignored with a cfg_err pulse.
- cfg_we and an in_valid handshake on the same IDLE edge: both take effect. The weight is written at that edge, and the run (which starts the next cycle) uses the new weight.
- Reset during RUN or DONE: aborts immediately. Results are discarded, weights are cleared, and no out_valid pulse is produced.
- in_vec changes after the handshake have no effect.

Optional Feature:
TERNARY_RELU_EN
- Defined: each neuron sum is clamped so negative values become 0 before being written to out_vec. Range becomes 0..+4.
- Undefined: raw signed sum is written.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package ternary_pkg contains:
  - crumb encoding constants TERN_ZERO=2'b00, TERN_POS=2'b01, TERN_NEG=2'b11, TERN_RSVD=2'b10
  - state enum {IDLE, RUN, DONE}
  - function/constant for the input count (4)
- One combinational sub-module, ternary_dot4: inputs (8-bit weight, 4-bit input), output SUM_W signed sum. The ReLU option is applied inside the sequencer, not in ternary_dot4.

Test Plan:
- Reset, write neuron0=8'h55 (all +1), send in_vec=4'b1111 -> after 4 edges out_valid=1, slot0=4'sd4, slots1..3=0.
- Weights n0=8'hFF, n1=8'h37 (crumbs 11,01,11,00), in_vec=4'b0111, N=4 -> slot0=-3 (4'hD), slot1=-1 (4'hF); with TERNARY_RELU_EN both read 0.
- Reserved crumbs: n2=8'hAA, in_vec=4'hF -> slot2=0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_vec stable, in_ready=0; assert out_ready -> IDLE and in_ready=1 on the next cycle.
- cfg_we during RUN with cfg_addr=1 -> weight unchanged, cfg_err high for one cycle; cfg_addr=N_NEURONS in IDLE -> cfg_err pulse, bank unchanged.
- Simultaneous IDLE cfg_we(n0=8'h03) and in_valid(in_vec=4'b0001) -> slot0=-1. Separately, reset asserted on the second RUN cycle -> out_valid never rises, and reading results after re-run with a new input gives 0s.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared ternary encoding, FSM state type and input count.
// Used by the layer sequencer, its dot-product unit and its interface.
package ternary_pkg;

    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_RSVD = 2'b10;

    localparam int N_INPUTS = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int n_inputs();
        return N_INPUTS;
    endfunction

endpackage

// File: rtl/ternary_layer_sequencer_if.sv
// Config, input-vector and result-vector bundle of the layer sequencer.
// master = source/consumer side, slave = sequencer side.
interface ternary_layer_sequencer_if #(
    parameter int N_NEURONS = 4,
    parameter int SUM_W     = 4
);
    localparam int AW = $clog2(N_NEURONS);

    logic                       cfg_we;
    logic [AW-1:0]              cfg_addr;
    logic [7:0]                 cfg_wdata;
    logic                       cfg_err;
    logic                       in_valid;
    logic                       in_ready;
    logic [3:0]                 in_vec;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_NEURONS*SUM_W-1:0] out_vec;
    logic                       busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        output in_valid, in_vec, out_ready,
        input  cfg_err, in_ready, out_valid,
        input  out_vec, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        input  in_valid, in_vec, out_ready,
        output cfg_err, in_ready, out_valid,
        output out_vec, busy
    );

endinterface

// File: rtl/ternary_dot4.sv
// Combinational 4-input ternary dot product: sum of +x, -x or 0 per crumb.
// Result range is -4..+4, returned as SUM_W-bit two's complement.
module ternary_dot4
    import ternary_pkg::*;
#(
    parameter int SUM_W = 4
) (
    input  logic [7:0]              w,
    input  logic [N_INPUTS-1:0]     x,
    output logic signed [SUM_W-1:0] sum
);

    // accumulate each crumb's contribution; reserved code counts as zero
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            case (w[2*k +: 2])
                TERN_POS:  sum = sum + SUM_W'(x[k]);
                TERN_NEG:  sum = sum - SUM_W'(x[k]);
                TERN_ZERO: sum = sum;
                TERN_RSVD: sum = sum;
                default:   sum = sum;
            endcase
        end
    end

endmodule

// File: rtl/ternary_layer_sequencer.sv
// One perceptron layer: a single ternary_dot4 shared over N_NEURONS weights.
// Build option TERNARY_RELU_EN clamps negative neuron sums to zero.
module ternary_layer_sequencer
    import ternary_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int SUM_W     = 4
) (
    input logic                      clk,
    input logic                      reset,
    ternary_layer_sequencer_if.slave bus
);

    localparam int AW = $clog2(N_NEURONS);

    state_t                  state;
    logic [AW-1:0]           idx;
    logic [N_INPUTS-1:0]     vec;
    logic [7:0]              wbank [N_NEURONS];
    logic signed [SUM_W-1:0] dot;
    logic signed [SUM_W-1:0] res;
    logic                    addr_ok;

    ternary_dot4 #(
        .SUM_W(SUM_W)
    ) u_dot (
        .w  (wbank[idx]),
        .x  (vec),
        .sum(dot)
    );

    assign addr_ok = 32'(bus.cfg_addr) < 32'(N_NEURONS);

    // optional activation applied to the shared dot-product result
    always_comb begin
        res = dot;
`ifdef TERNARY_RELU_EN
        if (dot[SUM_W-1]) begin
            res = '0;
        end
`endif
    end

    // control FSM, weight bank and result slots
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            vec           <= '0;
            bus.out_vec   <= '0;
            bus.out_valid <= 1'b0;
            bus.cfg_err   <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                wbank[n] <= 8'h00;
            end
        end else begin
            bus.cfg_err <= bus.cfg_we && (state != IDLE || !addr_ok);
            if (bus.cfg_we && state == IDLE && addr_ok) begin
                wbank[bus.cfg_addr] <= bus.cfg_wdata;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec          <= bus.in_vec;
                        idx          <= '0;
                        state        <= RUN;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int n = 0; n < N_NEURONS; n++) begin
                        if (idx == AW'(n)) begin
                            bus.out_vec[n*SUM_W +: SUM_W] <= res;
                        end
                    end
                    if (idx == AW'(N_NEURONS - 1)) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_layer_sequencer.sv
// Bench for ternary_layer_sequencer: directed cases plus random runs
// checked against an arithmetic model of the layer.
module tb_ternary_layer_sequencer;

    localparam int N  = 4;
    localparam int SW = 4;
    localparam int AW = $clog2(N);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ternary_layer_sequencer_if #(.N_NEURONS(N), .SUM_W(SW)) bus ();

    ternary_layer_sequencer #(
        .N_NEURONS(N),
        .SUM_W    (SW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int nchk = 0;
    int nerr = 0;

    logic [7:0]    wm [N];
    logic [SW-1:0] em [N];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int neuron(input logic [7:0] w, input logic [3:0] x);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            int c = int'(w[2*k +: 2]);
            if (c == 1) s = s + int'(x[k]);
            if (c == 3) s = s - int'(x[k]);
        end
`ifdef TERNARY_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic clear_model();
        for (int n = 0; n < N; n++) begin
            wm[n] = 8'h00;
            em[n] = '0;
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        clear_model();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        check("rst_out_vec", 64'(bus.out_vec), 64'd0);
    endtask

    task automatic cfg(input int a, input logic [7:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = AW'(a);
        bus.cfg_wdata = d;
        step();
        bus.cfg_we = 1'b0;
        check("cfg_err", 64'(bus.cfg_err), 64'(a >= N));
        if (a < N) wm[a] = d;
        step();
        check("cfg_err_clr", 64'(bus.cfg_err), 64'd0);
    endtask

    // mode 0: plain, 1: cfg write on the accept edge, 2: cfg write in RUN
    task automatic run(input logic [3:0] v, input int hold, input int mode,
                       input int ca, input logic [7:0] cd);
        int cyc;
        logic [N*SW-1:0] expv;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        if (mode == 1) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = AW'(ca);
            bus.cfg_wdata = cd;
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_vec   = 4'($urandom);
        bus.cfg_we   = 1'b0;
        if (mode == 1) begin
            check("cfg_err_accept", 64'(bus.cfg_err), 64'(ca >= N));
            if (ca < N) wm[ca] = cd;
        end
        check("busy_run", 64'(bus.busy), 64'd1);
        check("in_ready_run", 64'(bus.in_ready), 64'd0);
        if (mode == 2) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = AW'(ca);
            bus.cfg_wdata = cd;
        end
        cyc = 0;
        while (!bus.out_valid && cyc < N + 4) begin
            step();
            cyc++;
            bus.cfg_we = 1'b0;
            if (mode == 2 && cyc == 1)
                check("cfg_err_run", 64'(bus.cfg_err), 64'd1);
            if (mode == 2 && cyc == 2)
                check("cfg_err_run_clr", 64'(bus.cfg_err), 64'd0);
        end
        check("latency", 64'(cyc), 64'(N));
        for (int n = 0; n < N; n++) begin
            em[n] = SW'(neuron(wm[n], v));
            expv[n*SW +: SW] = em[n];
        end
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_vec", 64'(bus.out_vec), 64'(expv));
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        for (int n = 0; n < N; n++) begin
            check($sformatf("slot%0d", n),
                  64'(bus.out_vec[n*SW +: SW]), 64'(em[n]));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("done_valid_clr", 64'(bus.out_valid), 64'd0);
        check("done_in_ready", 64'(bus.in_ready), 64'd1);
        check("done_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic abort_run(input logic [3:0] v);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        step();
        bus.in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_model();
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < N + 3; i++) begin
            step();
            check("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        do_reset();

        cfg(0, 8'h55);
        run(4'b1111, 0, 0, 0, 8'h00);

        cfg(0, 8'hFF);
        cfg(1, 8'h37);
        cfg(2, 8'hAA);
        run(4'b0111, 10, 0, 0, 8'h00);
        run(4'hF, 1, 0, 0, 8'h00);

        run(4'hF, 2, 2, 1, 8'h5A);

        run(4'b0001, 0, 1, 0, 8'h03);

        cfg(1, 8'h11);
        abort_run(4'b1011);
        run(4'b1101, 0, 0, 0, 8'h00);

        for (int it = 0; it < 20; it++) begin
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(0, 1) == 1)
                    cfg(int'($urandom_range(0, (1 << AW) - 1)),
                        8'($urandom));
            end
            run(4'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)),
                int'($urandom_range(0, (1 << AW) - 1)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
